// File: rtl/mem_arb_pkg.sv
// Shared state/owner types and AddrMode encodings for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [2:0] MODE_LB  = 3'b000;
    localparam logic [2:0] MODE_LH  = 3'b001;
    localparam logic [2:0] MODE_LW  = 3'b010;
    localparam logic [2:0] MODE_LBU = 3'b011;
    localparam logic [2:0] MODE_LHU = 3'b100;
    localparam logic [2:0] MODE_SB  = 3'b101;
    localparam logic [2:0] MODE_SH  = 3'b110;
    localparam logic [2:0] MODE_SW  = 3'b111;

    function automatic logic is_store(input logic [2:0] mode);
        return (mode == MODE_SB) || (mode == MODE_SH) || (mode == MODE_SW);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and backing-memory signals of the arbiter.
// err exists only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [2:0]            d_addr_mode;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  m_req;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [2:0]            m_addr_mode;
    logic                  m_we;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_ack;

    logic                  busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic                  err;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_addr_mode, d_wdata, m_rdata, m_ack,
        output if_ready, if_rdata, d_ready, d_rdata,
        output m_req, m_addr, m_addr_mode, m_we, m_wdata, busy, err
    );
    modport master (
        output if_req, if_addr, d_req, d_addr, d_addr_mode, d_wdata, m_rdata, m_ack,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  m_req, m_addr, m_addr_mode, m_we, m_wdata, busy, err
    );
`else
    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_addr_mode, d_wdata, m_rdata, m_ack,
        output if_ready, if_rdata, d_ready, d_rdata,
        output m_req, m_addr, m_addr_mode, m_we, m_wdata, busy
    );
    modport master (
        output if_req, if_addr, d_req, d_addr, d_addr_mode, d_wdata, m_rdata, m_ack,
        input  if_ready, if_rdata, d_ready, d_rdata,
        input  m_req, m_addr, m_addr_mode, m_we, m_wdata, busy
    );
`endif

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts consecutive ACCESS cycles; expired flags the last allowed cycle without an ack.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero outside ACCESS, so each new ACCESS starts fresh.
    always_comb begin
        cnt_d = run ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store, data first.
// Define MEM_ARB_TIMEOUT_EN to add an ACCESS watchdog and the err output.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
        $error("mem_arbiter: MAX_D_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [3:0]            streak_q, streak_d;
    logic                  m_req_q, m_req_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [2:0]            m_addr_mode_q, m_addr_mode_d;
    logic                  m_we_q, m_we_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  pick_data;

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expired;

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q == ACCESS),
        .expired (wd_expired)
    );
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        streak_d      = streak_q;
        m_req_d       = m_req_q;
        m_addr_d      = m_addr_q;
        m_addr_mode_d = m_addr_mode_q;
        m_we_d        = m_we_q;
        m_wdata_d     = m_wdata_q;
        if_ready_d    = 1'b0;
        d_ready_d     = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        // Fetch wins a contested slot only once data has used up its streak.
        pick_data     = bus.d_req && !(bus.if_req && streak_q == STREAK_MAX);
`ifdef MEM_ARB_TIMEOUT_EN
        err_d         = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ACCESS;
                    m_req_d = 1'b1;
                    if (pick_data) begin
                        owner_d       = OWN_D;
                        m_addr_d      = bus.d_addr;
                        m_addr_mode_d = bus.d_addr_mode;
                        m_wdata_d     = bus.d_wdata;
                        if (!bus.if_req)                streak_d = '0;
                        else if (streak_q < STREAK_MAX) streak_d = streak_q + 4'd1;
                    end else begin
                        owner_d       = OWN_I;
                        m_addr_d      = bus.if_addr;
                        m_addr_mode_d = MODE_LW;
                        m_wdata_d     = '0;
                        streak_d      = '0;
                    end
                    m_we_d = is_store(m_addr_mode_d);
                end
            end
            ACCESS: begin
                if (bus.m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = is_store(m_addr_mode_q) ? '0 : bus.m_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.m_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            streak_q      <= '0;
            m_req_q       <= 1'b0;
            m_addr_q      <= '0;
            m_addr_mode_q <= 3'b000;
            m_we_q        <= 1'b0;
            m_wdata_q     <= '0;
            if_ready_q    <= 1'b0;
            d_ready_q     <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            streak_q      <= streak_d;
            m_req_q       <= m_req_d;
            m_addr_q      <= m_addr_d;
            m_addr_mode_q <= m_addr_mode_d;
            m_we_q        <= m_we_d;
            m_wdata_q     <= m_wdata_d;
            if_ready_q    <= if_ready_d;
            d_ready_q     <= d_ready_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q         <= err_d;
`endif
        end
    end

    assign bus.m_req       = m_req_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_addr_mode = m_addr_mode_q;
    assign bus.m_we        = m_we_q;
    assign bus.m_wdata     = m_wdata_q;
    assign bus.if_ready    = if_ready_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_ready     = d_ready_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.busy        = (state_q != IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err         = err_q;
`endif

endmodule
